// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the data-cache bus.
// Serves single-word dREN/dWEN requests from an internal 2**AW x 32 array.
// Each request is acknowledged after LAT wait cycles by holding dwait low for one cycle.
// Optional macro DMEM_PERF_EN adds rdcnt/wrcnt, which count acknowledged reads and writes.
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   asynchronous active-high reset
//   dREN    in   read request, held until acknowledged
//   dWEN    in   write request, held until acknowledged (wins over dREN)
//   daddr   in   byte address; word index = daddr[AW+1:2]
//   dstore  in   write data
//   dwait   out  low only in the acknowledge cycle
//   dload   out  read data, valid while dwait=0 for a read
//   rdcnt   out  (DMEM_PERF_EN) saturating count of acknowledged reads
//   wrcnt   out  (DMEM_PERF_EN) saturating count of acknowledged writes
module dmem_responder #(
  parameter int unsigned AW  = 10,
  parameter int unsigned LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] rdcnt,
  output logic [31:0] wrcnt
`endif
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW-1:0]   dload_q, dload_d;
  logic            dwait_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            req;
  logic            req_wr;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   rd_idx;
  logic            abort;
  logic            mem_we;
  logic            unused_addr_bits;

  assign req     = dREN | dWEN;
  assign req_wr  = dWEN;
  assign req_idx = daddr[AW+1:2];
  assign unused_addr_bits = ^{daddr[31:AW+2], daddr[1:0]};

  // A waiting request is dropped if the master withdraws it or changes op/word.
  assign abort = (state_q == BUSY) &&
                 (!req || (req_wr != wr_q) || (req_idx != idx_q));

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = (LAT > 0) ? BUSY : ACK;
      BUSY: begin
        if (abort)              state_d = IDLE;
        else if (cnt_q == '0)   state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    data_d  = data_q;
    dload_d = dload_q;
    rd_idx  = idx_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          idx_d  = req_idx;
          wr_d   = req_wr;
          data_d = dstore;
          rd_idx = req_idx;
          cnt_d  = (LAT > 0) ? CW'(LAT - 1) : '0;
        end
      end
      BUSY: if (!abort && (cnt_q != '0)) cnt_d = cnt_q - CW'(1);
      ACK:     mem_we = wr_q;
      default: ;
    endcase
    // Read data is captured on the edge that enters ACK.
    if ((state_d == ACK) && !wr_d) dload_d = mem[rd_idx];
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      dload_q <= '0;
      dwait_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      dload_q <= dload_d;
      dwait_q <= (state_d != ACK);
    end
  end

  // Write commits on the edge leaving ACK; reset forces IDLE first, suppressing it.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[idx_q] <= data_q;
  end

  assign dwait = dwait_q;
  assign dload = dload_q;

`ifdef DMEM_PERF_EN
  logic [31:0] rdcnt_q, wrcnt_q;

  // Saturating per-op acknowledge counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rdcnt_q <= '0;
      wrcnt_q <= '0;
    end else if (state_q == ACK) begin
      if (wr_q) begin
        if (wrcnt_q != '1) wrcnt_q <= wrcnt_q + 32'd1;
      end else begin
        if (rdcnt_q != '1) rdcnt_q <= rdcnt_q + 32'd1;
      end
    end
  end

  assign rdcnt = rdcnt_q;
  assign wrcnt = wrcnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LAT=2, LAT=0, LAT=3), directed
// vectors, multi-cycle abort/reset sequences and randomized traffic vs a model.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam int WORDS = 1024;

  int lat_of [NI] = '{2, 0, 3};

  logic        CLK = 1'b0;
  logic        rst   [NI];
  logic        ren   [NI];
  logic        wen   [NI];
  logic [31:0] addr  [NI];
  logic [31:0] store [NI];
  logic        dwait [NI];
  logic [31:0] dload [NI];
`ifdef DMEM_PERF_EN
  logic [31:0] rdcnt [NI];
  logic [31:0] wrcnt [NI];
`endif

  always #5 CLK = ~CLK;

  dmem_responder #(.AW(10), .LAT(2)) u_lat2 (
    .CLK(CLK), .RST(rst[0]), .dREN(ren[0]), .dWEN(wen[0]), .daddr(addr[0]),
    .dstore(store[0]), .dwait(dwait[0]), .dload(dload[0])
`ifdef DMEM_PERF_EN
    , .rdcnt(rdcnt[0]), .wrcnt(wrcnt[0])
`endif
  );

  dmem_responder #(.AW(10), .LAT(0)) u_lat0 (
    .CLK(CLK), .RST(rst[1]), .dREN(ren[1]), .dWEN(wen[1]), .daddr(addr[1]),
    .dstore(store[1]), .dwait(dwait[1]), .dload(dload[1])
`ifdef DMEM_PERF_EN
    , .rdcnt(rdcnt[1]), .wrcnt(wrcnt[1])
`endif
  );

  dmem_responder #(.AW(10), .LAT(3)) u_lat3 (
    .CLK(CLK), .RST(rst[2]), .dREN(ren[2]), .dWEN(wen[2]), .daddr(addr[2]),
    .dstore(store[2]), .dwait(dwait[2]), .dload(dload[2])
`ifdef DMEM_PERF_EN
    , .rdcnt(rdcnt[2]), .wrcnt(wrcnt[2])
`endif
  );

  // Reference model: word memory, last read data, ack counts.
  logic [31:0] ref_mem   [NI][WORDS];
  bit          ref_vld   [NI][WORDS];
  logic [31:0] ref_dload [NI];
  int          ref_rd    [NI];
  int          ref_wr    [NI];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  // One full request/ack handshake starting from IDLE at a negedge.
  task automatic xact(input int i, input bit rd, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_dload, input string tag);
    int n;
    n = 0;
    ren[i] = rd; wen[i] = wr; addr[i] = a; store[i] = d;
    do begin
      @(negedge CLK);
      n++;
    end while (dwait[i] === 1'b1 && n < 40);
    check32({tag, " latency"}, 32'(n), 32'(lat_of[i] + 1));
    check32({tag, " dload"}, dload[i], exp_dload);
    ren[i] = 1'b0; wen[i] = 1'b0;
    if (wr) begin
      ref_mem[i][widx(a)] = d;
      ref_vld[i][widx(a)] = 1'b1;
      ref_wr[i]++;
    end else begin
      ref_dload[i] = ref_mem[i][widx(a)];
      ref_rd[i]++;
    end
    @(negedge CLK);
    check32({tag, " ack one cycle"}, 32'(dwait[i]), 32'd1);
  endtask

  task automatic reset_model(input int i);
    ref_dload[i] = '0;
    ref_rd[i] = 0;
    ref_wr[i] = 0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; store[i] = '0;
      reset_model(i);
      for (int w = 0; w < WORDS; w++) ref_vld[i][w] = 1'b0;
    end

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_1004, 32'h1111_1111, 32'hA5A5_A5A5};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111};
    tbl[6] = '{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0000, 32'h1111_1111};

    repeat (2) @(negedge CLK);
    for (int i = 0; i < NI; i++) begin
      check32($sformatf("reset dwait[%0d]", i), 32'(dwait[i]), 32'd1);
      check32($sformatf("reset dload[%0d]", i), dload[i], 32'd0);
    end
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(negedge CLK);

    // Directed vectors on the LAT=2 instance
    for (int v = 0; v < 7; v++)
      xact(0, tbl[v].rd, tbl[v].wr, tbl[v].a, tbl[v].d, tbl[v].exp, $sformatf("vec%0d", v));

    // LAT=0: read straight after write
    xact(1, 1'b0, 1'b1, 32'h4, 32'h1234_5678, 32'h0, "lat0 wr");
    xact(1, 1'b1, 1'b0, 32'h4, 32'h0, 32'h1234_5678, "lat0 rd");

    // LAT=3: address change in first BUSY cycle aborts, then re-samples
    xact(2, 1'b0, 1'b1, 32'h20, 32'h2020_2020, 32'h0, "lat3 wr20");
    xact(2, 1'b0, 1'b1, 32'h24, 32'h2424_2424, 32'h0, "lat3 wr24");
    ren[2] = 1'b1; addr[2] = 32'h20;
    @(negedge CLK);
    check32("abort busy dwait", 32'(dwait[2]), 32'd1);
    addr[2] = 32'h24;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (dwait[2] === 1'b1 && n < 40);
    check32("abort reack latency", 32'(n), 32'd5);
    check32("abort reack dload", dload[2], 32'h2424_2424);
    ren[2] = 1'b0;
    ref_dload[2] = 32'h2424_2424;
    ref_rd[2]++;
    @(negedge CLK);

    // LAT=3: request withdrawn mid-BUSY never acknowledges
    ren[2] = 1'b1; addr[2] = 32'h20;
    @(negedge CLK);
    ren[2] = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (dwait[2] !== 1'b1) n++;
    end
    check32("drop abort no ack", 32'(n), 32'd0);
    check32("drop abort dload", dload[2], 32'h2424_2424);

    // LAT=2: reset during BUSY of a write leaves old data
    wen[0] = 1'b1; addr[0] = 32'h30; store[0] = 32'hCAFE_F00D;
    @(negedge CLK);
    rst[0] = 1'b1;
    #1;
    check32("rst busy dwait", 32'(dwait[0]), 32'd1);
    check32("rst busy dload", dload[0], 32'd0);
    wen[0] = 1'b0;
    @(negedge CLK);
    rst[0] = 1'b0;
    reset_model(0);
    @(negedge CLK);
    xact(0, 1'b1, 1'b0, 32'h30, 32'h0, 32'h0, "rst busy rd30");

    // LAT=0: reset during ACK of a write suppresses it
    xact(1, 1'b0, 1'b1, 32'h34, 32'h0BAD_F00D, 32'h1234_5678, "lat0 wr34");
    wen[1] = 1'b1; addr[1] = 32'h34; store[1] = 32'h5555_AAAA;
    @(negedge CLK);
    check32("rst ack in ack", 32'(dwait[1]), 32'd0);
    rst[1] = 1'b1;
    #1;
    check32("rst ack dwait", 32'(dwait[1]), 32'd1);
    wen[1] = 1'b0;
    @(negedge CLK);
    rst[1] = 1'b0;
    reset_model(1);
    @(negedge CLK);
    xact(1, 1'b1, 1'b0, 32'h34, 32'h0, 32'h0BAD_F00D, "rst ack rd34");

    // Randomized traffic with aliased addresses against the model
    for (int t = 0; t < 90; t++) begin
      int i, w;
      bit rd, wr;
      logic [31:0] a, d, e;
      i  = int'($urandom_range(0, NI - 1));
      a  = (32'($urandom_range(0, 7)) << 12) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
      d  = $urandom;
      w  = widx(a);
      wr = ($urandom_range(0, 1) == 1) || !ref_vld[i][w];
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      e  = wr ? ref_dload[i] : ref_mem[i][w];
      xact(i, rd, wr, a, d, e, $sformatf("rnd%0d", t));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

`ifdef DMEM_PERF_EN
    for (int i = 0; i < NI; i++) begin
      check32($sformatf("rdcnt[%0d]", i), rdcnt[i], 32'(ref_rd[i]));
      check32($sformatf("wrcnt[%0d]", i), wrcnt[i], 32'(ref_wr[i]));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
